// File: rtl/spi_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_ctrl_pkg
// Brief    : Shared widths, slave constants, state encoding and slave-select
//            decode helper for the SPI transaction controller.
//            The GAP state exists only when SPI_CTRL_GAP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package spi_ctrl_pkg;

    localparam int         SPI_BYTE_W        = 8;
    localparam int         SPI_NUM_SLAVES    = 3;
    localparam logic [1:0] SPI_SLAVE_ILLEGAL = 2'd3;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_ST_IDLE    = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_LOAD    = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_SHIFT   = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_CAPTURE = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_RESP    = 3'd4;
`ifdef SPI_CTRL_GAP_EN
    localparam logic [c_STATE_W-1:0] c_ST_GAP     = 3'd5;
`endif

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE    = c_ST_IDLE,
        ST_LOAD    = c_ST_LOAD,
        ST_SHIFT   = c_ST_SHIFT,
        ST_CAPTURE = c_ST_CAPTURE,
        ST_RESP    = c_ST_RESP
`ifdef SPI_CTRL_GAP_EN
        ,
        ST_GAP     = c_ST_GAP
`endif
    } state_t;

    // Active-low select vector with only the addressed slave driven low.
    function automatic logic [SPI_NUM_SLAVES-1:0] ss_select_n(input logic [1:0] slave);
        logic [SPI_NUM_SLAVES-1:0] v;
        v = '1;
        case (slave)
            2'd0:    v = 3'b110;
            2'd1:    v = 3'b101;
            2'd2:    v = 3'b011;
            default: v = '1;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : spi_bit_counter
// Brief    : 3-bit bit-position counter with clear and enable; flags the
//            terminal count 7 that ends a byte exchange.
// Revision : 1.0 - initial release
// ============================================================================
module spi_bit_counter (
    input  logic sclk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [2:0] r_count;

    // Count bit positions; clear has priority over enable.
    always_ff @(posedge sclk) begin
        if (!reset) begin
            r_count <= 3'd0;
        end else if (i_clr) begin
            r_count <= 3'd0;
        end else if (i_en) begin
            r_count <= r_count + 3'd1;
        end
    end

    assign o_tc = (r_count == 3'd7);

endmodule
`default_nettype wire

// File: rtl/spi_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_txn_ctrl
// Brief    : Turns one request (slave index + byte) into the SPI core's load
//            pulse, an 8-cycle slave-select window and a captured receive
//            byte returned on a valid/ready response port.
//            Optional macro SPI_CTRL_GAP_EN inserts GAP_CYCLES idle cycles
//            after every response handshake.
// Revision : 1.0 - initial release
// ============================================================================
module spi_txn_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int GAP_CYCLES = 4
) (
    input  logic                  sclk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_slave,
    input  logic [SPI_BYTE_W-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [SPI_BYTE_W-1:0] rsp_data,
    output logic                  rsp_err,
    output logic [SPI_BYTE_W-1:0] datain,
    output logic                  load,
    output logic                  ss0,
    output logic                  ss1,
    output logic                  ss2,
    input  logic [SPI_BYTE_W-1:0] miso_in
);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_gap_range_chk
        $error("spi_txn_ctrl: GAP_CYCLES must be within 1..15");
    end

    state_t                    r_state,     w_state_next;
    logic [SPI_BYTE_W-1:0]     r_datain,    w_datain_next;
    logic [1:0]                r_slave,     w_slave_next;
    logic                      r_load,      w_load_next;
    logic [SPI_NUM_SLAVES-1:0] r_ss_n,      w_ss_n_next;
    logic                      r_rsp_valid, w_rsp_valid_next;
    logic [SPI_BYTE_W-1:0]     r_rsp_data,  w_rsp_data_next;
    logic                      r_rsp_err,   w_rsp_err_next;
    logic                      w_req_hs;
    logic                      w_bit_tc;
`ifdef SPI_CTRL_GAP_EN
    logic [3:0]                r_gap_cnt,   w_gap_cnt_next;
`endif

    // Ready is a pure state decode, held low while reset is asserted.
    assign req_ready = reset && (r_state == ST_IDLE);
    assign w_req_hs  = req_valid && req_ready;

    spi_bit_counter u_bit_counter (
        .sclk  (sclk),
        .reset (reset),
        .i_clr (r_state == ST_LOAD),
        .i_en  (r_state == ST_SHIFT),
        .o_tc  (w_bit_tc)
    );

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_next     = r_state;
        w_datain_next    = r_datain;
        w_slave_next     = r_slave;
        w_load_next      = 1'b0;
        w_ss_n_next      = '1;
        w_rsp_valid_next = r_rsp_valid;
        w_rsp_data_next  = r_rsp_data;
        w_rsp_err_next   = r_rsp_err;
`ifdef SPI_CTRL_GAP_EN
        w_gap_cnt_next   = r_gap_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_req_hs) begin
                    if (req_slave == SPI_SLAVE_ILLEGAL) begin
                        // Rejected without touching the bus.
                        w_state_next     = ST_RESP;
                        w_rsp_valid_next = 1'b1;
                        w_rsp_err_next   = 1'b1;
                        w_rsp_data_next  = '0;
                    end else begin
                        w_state_next  = ST_LOAD;
                        w_slave_next  = req_slave;
                        w_datain_next = req_data;
                        w_load_next   = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                w_state_next = ST_SHIFT;
                w_ss_n_next  = ss_select_n(r_slave);
            end
            ST_SHIFT: begin
                // Select stays low through count 7, released on the exit edge.
                if (w_bit_tc) begin
                    w_state_next = ST_CAPTURE;
                end else begin
                    w_ss_n_next = ss_select_n(r_slave);
                end
            end
            ST_CAPTURE: begin
                w_state_next     = ST_RESP;
                w_rsp_valid_next = 1'b1;
                w_rsp_err_next   = 1'b0;
                w_rsp_data_next  = miso_in;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_next = 1'b0;
`ifdef SPI_CTRL_GAP_EN
                    w_state_next     = ST_GAP;
                    w_gap_cnt_next   = 4'(GAP_CYCLES - 1);
`else
                    w_state_next     = ST_IDLE;
`endif
                end
            end
`ifdef SPI_CTRL_GAP_EN
            ST_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_gap_cnt_next = r_gap_cnt - 4'd1;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer immediately.
    always_ff @(posedge sclk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_datain    <= '0;
            r_slave     <= 2'd0;
            r_load      <= 1'b0;
            r_ss_n      <= '1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
`ifdef SPI_CTRL_GAP_EN
            r_gap_cnt   <= 4'd0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_datain    <= w_datain_next;
            r_slave     <= w_slave_next;
            r_load      <= w_load_next;
            r_ss_n      <= w_ss_n_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_data  <= w_rsp_data_next;
            r_rsp_err   <= w_rsp_err_next;
`ifdef SPI_CTRL_GAP_EN
            r_gap_cnt   <= w_gap_cnt_next;
`endif
        end
    end

    assign datain    = r_datain;
    assign load      = r_load;
    assign ss0       = r_ss_n[0];
    assign ss1       = r_ss_n[1];
    assign ss2       = r_ss_n[2];
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_txn_ctrl
// Brief    : Self-checking bench for spi_txn_ctrl driving a behavioural
//            three-slave full-duplex shift core. Expected response bytes come
//            from a per-slave memory model: each legal exchange returns the
//            byte last written to that slave and stores the new one.
//            Honours SPI_CTRL_GAP_EN for the idle-gap expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_txn_ctrl;

    localparam int GAP_CYCLES = 4;
`ifdef SPI_CTRL_GAP_EN
    localparam int c_GAP_EFF = GAP_CYCLES;
`else
    localparam int c_GAP_EFF = 0;
`endif

    logic       sclk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_slave = 2'd0;
    logic [7:0] req_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [7:0] datain;
    logic       load;
    logic       ss0, ss1, ss2;
    logic [7:0] miso_in;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: last byte written into each slave register.
    logic [7:0] m_slave [3];
    bit         m_known [3];

    always #5 sclk = ~sclk;

    spi_txn_ctrl #(.GAP_CYCLES(GAP_CYCLES)) dut (
        .sclk      (sclk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_slave (req_slave),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .datain    (datain),
        .load      (load),
        .ss0       (ss0),
        .ss1       (ss1),
        .ss2       (ss2),
        .miso_in   (miso_in)
    );

    // Behavioural SPI core: master/slave registers rotate MSB-first.
    logic       core_rst = 1'b1;
    logic [7:0] core_m;
    logic [7:0] core_s [3];

    always @(posedge sclk) begin
        if (core_rst) begin
            core_m <= 8'h00;
            for (int i = 0; i < 3; i++) core_s[i] <= 8'h00;
        end else if (load) begin
            core_m <= datain;
        end else if (!ss0) begin
            core_m    <= {core_m[6:0], core_s[0][7]};
            core_s[0] <= {core_s[0][6:0], core_m[7]};
        end else if (!ss1) begin
            core_m    <= {core_m[6:0], core_s[1][7]};
            core_s[1] <= {core_s[1][6:0], core_m[7]};
        end else if (!ss2) begin
            core_m    <= {core_m[6:0], core_s[2][7]};
            core_s[2] <= {core_s[2][6:0], core_m[7]};
        end
    end

    assign miso_in = core_m;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete request/response transaction with full cycle tracking.
    task automatic do_txn(input logic [1:0] s, input logic [7:0] d,
                          input int hold, input bit chk_wait);
        int         wk;
        int         lat;
        int         nload;
        int         first_ss;
        int         ssc [3];
        bit         bad_ready;
        bit         bad_hold;
        bit         legal;
        bit         exp_known;
        logic [7:0] exp_rsp;
        logic [7:0] held;

        legal = (s != 2'd3);
        exp_rsp = 8'h00;
        exp_known = 1'b1;
        if (legal) begin
            exp_rsp   = m_slave[s];
            exp_known = m_known[s];
            m_slave[s] = d;
            m_known[s] = 1'b1;
        end

        req_valid = 1'b1;
        req_slave = s;
        req_data  = d;
        wk = 0;
        while (!req_ready && wk < 60) begin
            @(negedge sclk);
            wk++;
        end
        if (chk_wait) check("req_ready_wait_cycles", wk, c_GAP_EFF);
        check("req_accepted", req_ready, 1'b1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end

        lat = 0; nload = 0; first_ss = 0; bad_ready = 1'b0;
        for (int i = 0; i < 3; i++) ssc[i] = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge sclk);
            if (k == 1) req_valid = 1'b0;
            if (req_ready !== 1'b0) bad_ready = 1'b1;
            if (load === 1'b1) begin
                nload++;
                if (k == 1) check("datain_at_load", datain, d);
            end
            if (!ss0) ssc[0]++;
            if (!ss1) ssc[1]++;
            if (!ss2) ssc[2]++;
            if (first_ss == 0 && (!ss0 || !ss1 || !ss2)) first_ss = k;
            if (rsp_valid === 1'b1) begin
                lat = k;
                break;
            end
            // Stray ready with no response pending must be ignored.
            if (legal) rsp_ready = (k >= 2 && k <= 8) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        rsp_ready = 1'b0;

        check("rsp_latency", lat, legal ? 11 : 1);
        check("load_pulses", nload, legal ? 1 : 0);
        for (int i = 0; i < 3; i++)
            check($sformatf("ss%0d_low_cycles", i), ssc[i], (legal && i == int'(s)) ? 8 : 0);
        if (legal) check("ss_first_low_cycle", first_ss, 2);
        check("req_ready_low_while_busy", bad_ready, 1'b0);
        check("rsp_err", rsp_err, !legal);
        if (exp_known) check("rsp_data", rsp_data, exp_rsp);

        held = rsp_data;
        bad_hold = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge sclk);
            if (rsp_valid !== 1'b1 || rsp_data !== held || rsp_err !== !legal ||
                req_ready !== 1'b0 || {ss0, ss1, ss2} !== 3'b111 || load !== 1'b0)
                bad_hold = 1'b1;
        end
        if (hold > 0) check("resp_hold_stable", bad_hold, 1'b0);

        rsp_ready = 1'b1;
        @(negedge sclk);
        rsp_ready = 1'b0;
        check("rsp_valid_after_handshake", rsp_valid, 1'b0);
    endtask

    initial begin
        int wk;
        for (int i = 0; i < 3; i++) begin
            m_slave[i] = 8'h00;
            m_known[i] = 1'b1;
        end

        // Reset state.
        reset = 1'b0;
        core_rst = 1'b1;
        repeat (3) @(negedge sclk);
        check("reset_load", load, 1'b0);
        check("reset_datain", datain, 8'h00);
        check("reset_ss", {ss0, ss1, ss2}, 3'b111);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_data", rsp_data, 8'h00);
        check("reset_rsp_err", rsp_err, 1'b0);
        check("reset_req_ready_forced_low", req_ready, 1'b0);
        reset = 1'b1;
        core_rst = 1'b0;
        @(negedge sclk);
        check("req_ready_after_reset", req_ready, 1'b1);

        // First exchange returns the core's reset byte and deposits A5.
        do_txn(2'd0, 8'hA5, 0, 1'b0);
        check("core_slave0_reg", core_s[0], 8'hA5);

        // Follow-up reads back A5.
        do_txn(2'd0, 8'h3C, 0, 1'b1);

        // Illegal slave index.
        do_txn(2'd3, 8'hFF, 0, 1'b1);

        // Host stalls the response for five cycles.
        do_txn(2'd1, 8'h96, 5, 1'b1);

        // Abort a slave-2 transfer in its fourth shift cycle.
        wk = 0;
        while (!req_ready && wk < 60) begin
            @(negedge sclk);
            wk++;
        end
        check("abort_req_ready_wait_cycles", wk, c_GAP_EFF);
        req_valid = 1'b1;
        req_slave = 2'd2;
        req_data  = 8'h5A;
        @(negedge sclk);
        req_valid = 1'b0;
        check("abort_load_pulse", load, 1'b1);
        repeat (4) @(negedge sclk);
        check("abort_ss2_low_in_shift", ss2, 1'b0);
        reset = 1'b0;
        @(negedge sclk);
        check("abort_ss2_released", ss2, 1'b1);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_load", load, 1'b0);
        check("abort_datain", datain, 8'h00);
        check("abort_req_ready_in_reset", req_ready, 1'b0);
        reset = 1'b1;
        m_known[2] = 1'b0;
        @(negedge sclk);
        check("abort_req_ready_after_reset", req_ready, 1'b1);
        repeat (3) @(negedge sclk);
        check("abort_no_response", rsp_valid, 1'b0);

        // Randomized traffic against the slave-memory model.
        for (int n = 0; n < 24; n++) begin
            do_txn(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 3), n != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_txn_ctrl.md
# spi_txn_ctrl

Transaction sequencer that sits directly upstream of the three-slave SPI shift core. It turns one request (slave index plus transmit byte) into the core's `load` pulse, an 8-cycle active-low slave-select window, and a captured receive byte. The receive byte is returned on a valid/ready response port. It runs on the same `sclk` as the core, so the core's 8-bit full-duplex exchange becomes a single handshake for the host logic.

## Interface
Parameters:
- `GAP_CYCLES`, default 4: idle cycles forced between transactions; used only when `SPI_CTRL_GAP_EN` is defined. Legal range 1–15.

Ports:
- `sclk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_slave`  in  2  target slave: 0/1/2 select ss0/ss1/ss2; 3 is illegal.
- `req_data`  in  8  byte to transmit.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  host accepts the response.
- `rsp_data`  out  8  byte received from the slave.
- `rsp_err`  out  1  request was rejected (illegal slave).
- `datain`  out  8  to core `datain`.
- `load`  out  1  to core `load`.
- `ss0`, `ss1`, `ss2`  out  1 each  to core, active-low.
- `miso_in`  in  8  core MISO register, read back.

## Operation
- States: IDLE, LOAD, SHIFT, CAPTURE, RESP, GAP (GAP exists only with the macro).
- IDLE: `req_ready` = 1.
  - On handshake with `req_slave` ≤ 2: latch slave and data, go to LOAD.
  - On handshake with `req_slave` = 3: go to RESP with `rsp_err` = 1 and `rsp_data` = 0. No ss is asserted.
- LOAD: one cycle with `load` = 1 and `datain` = latched byte. All ss outputs stay high. Next state: SHIFT.
- SHIFT: exactly 8 cycles with the selected ss low and the others high. A 3-bit counter runs 0..7; leave SHIFT when it reads 7.
- CAPTURE: one cycle. All ss are high and `rsp_data` ← `miso_in`. Next state: RESP.
- RESP: `rsp_valid` = 1. `rsp_data` and `rsp_err` are held stable until `rsp_ready`.
  - On handshake, go to GAP (macro defined) or IDLE (macro not defined).
- `req_ready` is 0 in every state except IDLE. Requests are never queued.
- `rsp_valid` and `rsp_ready` in the same cycle counts as a handshake.
- `rsp_ready` asserted with no `rsp_valid` is ignored.

## Timing
- All outputs are registered except `req_ready`, which is decoded from state and forced to 0 while `reset` is low.
- Reset values: `load` = 0, `datain` = 0, `ss0`/`ss1`/`ss2` = 1, `rsp_valid` = 0, `rsp_data` = 0, `rsp_err` = 0, state = IDLE.
- Request handshake in cycle T gives:
  - `load` high in T+1;
  - ss low in T+2..T+9;
  - capture in T+10;
  - `rsp_valid` from T+11.
- Legal request latency to `rsp_valid` is therefore 11 cycles. Illegal-slave requests have `rsp_valid` from T+1.
- A response handshake in cycle R gives `req_ready` = 1 in R+1 (no macro) or R+1+`GAP_CYCLES` (macro).
- Reset low in any state: every output returns to its reset value at that edge. ss deasserts immediately and no response is issued for the aborted transfer.
- The core has no external reset from this block, so its slave registers keep any partial shift.

## Configuration
- `SPI_CTRL_GAP_EN`:
  - Defined: after each response handshake, hold GAP for `GAP_CYCLES` cycles with all ss high and `req_ready` = 0, using a 4-bit down-counter.
  - Not defined: the GAP state and counter are not compiled, and RESP returns straight to IDLE.

## Structure
- Package `spi_ctrl_pkg` holds:
  - the state encoding constants;
  - `SPI_BYTE_W` = 8;
  - `SPI_NUM_SLAVES` = 3;
  - `SPI_SLAVE_ILLEGAL` = 2'd3.
- One sub-module, `spi_bit_counter`: a 3-bit counter with clear and enable that flags terminal count 7, used by SHIFT.

## Test plan
Bench uses a real core instance driven by this block; the core is reset once at start.
- Slave 0, `req_data` 8'hA5 after reset → `rsp_data` = 8'h00 at T+11, core MOSI_S1 = 8'hA5, ss0 low for exactly 8 cycles.
- Follow-up: slave 0, 8'h3C → `rsp_data` = 8'hA5, `rsp_err` = 0.
- `req_slave` = 3, data 8'hFF → `rsp_valid` at T+1 with `rsp_err` = 1, `rsp_data` = 8'h00, no ss low, no `load`.
- `rsp_ready` held low for 5 cycles in RESP → `rsp_valid`/`rsp_data` stable throughout, `req_ready` = 0, ss all high.
- Reset low in the 4th SHIFT cycle of a slave-2 transfer → next cycle ss2 = 1, `rsp_valid` = 0; `req_ready` = 1 the cycle after reset returns high.
- Macro defined, `GAP_CYCLES` = 4: response handshake at R → `req_ready` first high at R+5; a `req_valid` held high from R+1 is accepted at R+5.
